// File: rtl/simple_circuit_sweep_ctrl.sv
// Sweep sequencer for the 3-input evaluator: walks ABC = 0..7 with a programmable
// dwell, captures x/y into truth tables and scores them against the golden function.
module simple_circuit_sweep_ctrl #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         abc_out,
  input  logic               x_in,
  input  logic               y_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [7:0]         truth_x,
  output logic [7:0]         truth_y,
  output logic [3:0]         mismatch_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         vec_q, vec_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_lat_q, dwell_lat_d;
  logic [2:0]         abc_q, abc_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [7:0]         tx_q, tx_d;
  logic [7:0]         ty_q, ty_d;
  logic [3:0]         mc_q, mc_d;

  // Reference behaviour of the evaluator; vec bit 0 = A, bit 1 = B, bit 2 = C.
  function automatic logic golden_x(input logic [2:0] v);
    return (v[0] & v[1]) | ~v[2];
  endfunction

  function automatic logic golden_y(input logic [2:0] v);
    return ~v[2];
  endfunction

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    dwell_lat_d = dwell_lat_q;
    abc_d       = abc_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    tx_d        = tx_q;
    ty_d        = ty_q;
    mc_d        = mc_q;

    case (state_q)
      S_IDLE: begin
        abc_d  = 3'd0;
        busy_d = 1'b0;
        if (start) begin
          state_d     = S_APPLY;
          vec_d       = 3'd0;
          cnt_d       = dwell;
          dwell_lat_d = dwell;
          busy_d      = 1'b1;
          tx_d        = 8'h00;
          ty_d        = 8'h00;
          mc_d        = 4'd0;
          pass_d      = 1'b0;
        end
      end

      S_APPLY: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          abc_d   = 3'd0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else begin
          state_d = S_SAMPLE;
        end
      end

      S_SAMPLE: begin
        // Capture happens even when abort wins the state transition.
        tx_d[vec_q] = x_in;
        ty_d[vec_q] = y_in;
        if ((x_in != golden_x(vec_q)) || (y_in != golden_y(vec_q)))
          mc_d = mc_q + 4'd1;
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          abc_d   = 3'd0;
        end else if (vec_q == 3'd7) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          abc_d   = 3'd0;
          done_d  = 1'b1;
          pass_d  = (mc_d == 4'd0);
        end else begin
          state_d = S_APPLY;
          vec_d   = vec_q + 3'd1;
          abc_d   = vec_q + 3'd1;
          cnt_d   = dwell_lat_q;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        abc_d   = 3'd0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        abc_d   = 3'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vec_q       <= 3'd0;
      cnt_q       <= '0;
      dwell_lat_q <= '0;
      abc_q       <= 3'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      tx_q        <= 8'h00;
      ty_q        <= 8'h00;
      mc_q        <= 4'd0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      dwell_lat_q <= dwell_lat_d;
      abc_q       <= abc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      tx_q        <= tx_d;
      ty_q        <= ty_d;
      mc_q        <= mc_d;
    end
  end

  assign abc_out      = abc_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign truth_x      = tx_q;
  assign truth_y      = ty_q;
  assign mismatch_cnt = mc_q;

endmodule

// File: tb/tb_simple_circuit_sweep_ctrl.sv
// Bench for simple_circuit_sweep_ctrl: behavioural evaluator plus a queue of
// expected per-cycle vectors, with final truth tables checked against golden values.
module tb_simple_circuit_sweep_ctrl;

  localparam int DWELL_W = 4;

  logic               clk;
  logic               clk_en;
  logic               rst;
  logic               start;
  logic               abort;
  logic [DWELL_W-1:0] dwell;
  logic [2:0]         abc_out;
  logic               x_in;
  logic               y_in;
  logic               busy;
  logic               done;
  logic               pass;
  logic [7:0]         truth_x;
  logic [7:0]         truth_y;
  logic [3:0]         mismatch_cnt;
  logic               stuck_x;

  int checks;
  int errors;

  logic [2:0] exp_q[$];

  simple_circuit_sweep_ctrl #(.DWELL_W(DWELL_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .dwell        (dwell),
    .abc_out      (abc_out),
    .x_in         (x_in),
    .y_in         (y_in),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .truth_x      (truth_x),
    .truth_y      (truth_y),
    .mismatch_cnt (mismatch_cnt)
  );

  // Evaluator model, optionally with x stuck at 0.
  assign x_in = stuck_x ? 1'b0 : ((abc_out[0] & abc_out[1]) | ~abc_out[2]);
  assign y_in = ~abc_out[2];

  initial begin
    clk = 1'b0;
    forever #5 clk = clk_en ? ~clk : clk;
  end

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({abc_out, busy, done, pass, truth_x, truth_y, mismatch_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got abc=%0h busy=%0b done=%0b pass=%0b tx=%0h ty=%0h mc=%0d, want all 0",
               abc_out, busy, done, pass, truth_x, truth_y, mismatch_cnt);
    end
    #1 rst = 1'b0;
    clk_en = 1'b1;
  endtask

  // Full sweep: per-cycle vector check, done timing, final tables, then start held in DONE.
  task automatic test_sweep(input string nm, input int dw, input bit stuck,
                            input int repulse_at, input int dwell_chg_at,
                            input logic [7:0] ex, input logic [7:0] ey,
                            input logic [3:0] emc, input logic epass);
    int n;
    logic [2:0] e;
    n = 8 * (dw + 2);
    stuck_x = stuck;
    exp_q.delete();
    for (int v = 0; v < 8; v++)
      for (int c = 0; c < dw + 2; c++)
        exp_q.push_back(v[2:0]);
    @(negedge clk);
    dwell = DWELL_W'(dw);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < n; k++) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s_queue: scoreboard empty at cycle %0d", nm, k);
      end else begin
        e = exp_q.pop_front();
        if (abc_out !== e || busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL %s_cycle%0d: got abc=%0d busy=%0b done=%0b, want abc=%0d busy=1 done=0",
                   nm, k, abc_out, busy, done, e);
        end
      end
      if (k == repulse_at) start = 1'b1;
      if (k == dwell_chg_at) dwell = '0;
      @(posedge clk);
      #1 start = 1'b0;
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || abc_out !== 3'd0) begin
      errors++;
      $display("FAIL %s_done: got done=%0b busy=%0b abc=%0d, want done=1 busy=0 abc=0",
               nm, done, busy, abc_out);
    end
    checks++;
    if (truth_x !== ex || truth_y !== ey || mismatch_cnt !== emc || pass !== epass) begin
      errors++;
      $display("FAIL %s_result: got tx=%0h ty=%0h mc=%0d pass=%0b, want tx=%0h ty=%0h mc=%0d pass=%0b",
               nm, truth_x, truth_y, mismatch_cnt, pass, ex, ey, emc, epass);
    end
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || pass !== epass) begin
      errors++;
      $display("FAIL %s_after_done: got done=%0b busy=%0b pass=%0b, want done=0 busy=0 pass=%0b",
               nm, done, busy, pass, epass);
    end
    stuck_x = 1'b0;
  endtask

  task automatic test_abort();
    int done_seen;
    @(negedge clk);
    dwell = '0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (abc_out !== 3'd5 || busy !== 1'b1 || pass !== 1'b0) begin
      errors++;
      $display("FAIL abort_pre: got abc=%0d busy=%0b pass=%0b, want abc=5 busy=1 pass=0", abc_out, busy, pass);
    end
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || abc_out !== 3'd0) begin
      errors++;
      $display("FAIL abort_stop: got busy=%0b abc=%0d, want busy=0 abc=0", busy, abc_out);
    end
    checks++;
    if (truth_x[4:0] !== 5'h0F || truth_y[4:0] !== 5'h0F || mismatch_cnt !== 4'd0) begin
      errors++;
      $display("FAIL abort_partial: got tx=%0h ty=%0h mc=%0d, want tx[4:0]=0f ty[4:0]=0f mc=0",
               truth_x, truth_y, mismatch_cnt);
    end
    done_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen != 0 || pass !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet: got %0d cycles with done/busy, pass=%0b, want 0 and pass=0", done_seen, pass);
    end
  endtask

  task automatic test_reset_mid_sweep();
    @(negedge clk);
    dwell = 4'd2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || truth_x === 8'h00) begin
      errors++;
      $display("FAIL midrst_pre: got busy=%0b tx=%0h, want busy=1 tx nonzero", busy, truth_x);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({abc_out, busy, done, pass, truth_x, truth_y, mismatch_cnt} !== '0) begin
      errors++;
      $display("FAIL midrst_clear: got abc=%0h busy=%0b done=%0b pass=%0b tx=%0h ty=%0h mc=%0d, want all 0",
               abc_out, busy, done, pass, truth_x, truth_y, mismatch_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || abc_out !== 3'd0) begin
      errors++;
      $display("FAIL midrst_idle: got busy=%0b abc=%0d, want busy=0 abc=0", busy, abc_out);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    clk_en  = 1'b0;
    rst     = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    dwell   = '0;
    stuck_x = 1'b0;
    #2;
    test_reset();
    repeat (2) @(posedge clk);
    test_sweep("dwell0", 0, 1'b0, -1, -1, 8'h8F, 8'h0F, 4'd0, 1'b1);
    test_sweep("dwell3", 3, 1'b0, -1, 2, 8'h8F, 8'h0F, 4'd0, 1'b1);
    test_abort();
    test_sweep("stuckx", 0, 1'b1, -1, -1, 8'h00, 8'h0F, 4'd5, 1'b0);
    test_sweep("repulse", 0, 1'b0, 5, -1, 8'h8F, 8'h0F, 4'd0, 1'b1);
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
